// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the LoongArch 5-stage pipeline.
// Collects data-SRAM responses, extends load data, forwards results to WB
// and ID, and discards responses belonging to flushed requests.
// Optional feature macro: MEM_LOAD_BYPASS_EN (forward load data to ID in
// the same cycle the counted response arrives).
module mem_stage #(
  parameter int DISCARD_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] ex_pc,
  input  logic        ex_gr_we,
  input  logic [4:0]  ex_dest,
  input  logic [31:0] ex_alu_result,
  input  logic [2:0]  ex_ld_op,
  input  logic        ex_req_issued,
  input  logic        ex_ex,
  input  logic [5:0]  ex_ecode,
  input  logic [8:0]  ex_esubcode,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  output logic        mem_wb_valid,
  input  logic        wb_allowin,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic [31:0] mem_vaddr,
  output logic        mem_gr_we,
  output logic [4:0]  mem_dest,
  output logic        mem_ex,
  output logic [5:0]  mem_ecode,
  output logic [8:0]  mem_esubcode,
  output logic        fwd_we,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic        fwd_block
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_e;

  localparam logic [DISCARD_W-1:0] CntMax = '1;

  logic                 valid_q, valid_d;
  logic [31:0]          pc_q;
  logic                 gr_we_q;
  logic [4:0]           dest_q;
  logic [31:0]          alu_result_q;
  logic [2:0]           ld_op_q;
  logic                 req_issued_q;
  logic                 ex_q;
  logic [5:0]           ecode_q;
  logic [8:0]           esubcode_q;
  logic                 resp_buf_v_q, resp_buf_v_d;
  logic [31:0]          resp_buf_q, resp_buf_d;
  logic [DISCARD_W-1:0] discard_cnt_q, discard_cnt_d;

  state_e      state;
  logic        need_resp, cnt_zero, counted_ok, resp_got, ready_go;
  logic        capture, leave, is_load, block_base;
  logic [31:0] src_data, load_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [1:0]  inc;
  logic        dec;
  logic [DISCARD_W+1:0] cnt_sum;

  // Derive the effective stage state and the EX/WB handshake signals.
  always_comb begin
    need_resp   = valid_q & req_issued_q;
    cnt_zero    = (discard_cnt_q == '0);
    counted_ok  = data_sram_data_ok & cnt_zero;
    resp_got    = resp_buf_v_q | counted_ok;
    state       = S_READY;
    if (!valid_q) begin
      state = S_IDLE;
    end else if (need_resp && !resp_got) begin
      state = S_WAIT;
    end
    ready_go     = (state != S_WAIT);
    mem_allowin  = (state == S_IDLE) | ((state == S_READY) & wb_allowin);
    capture      = ex_mem_valid & mem_allowin & ~flush;
    leave        = (state == S_READY) & wb_allowin;
    mem_wb_valid = valid_q & ready_go & ~flush;
  end

  // Next-state of valid, the response buffer and the stale-response counter.
  // On flush, any request EX issued this cycle is stale whether or not MEM
  // takes it, and a waiting request with no counted response is stale too.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (mem_allowin) begin
      valid_d = ex_mem_valid;
    end

    resp_buf_v_d = resp_buf_v_q;
    resp_buf_d   = resp_buf_q;
    if (flush || leave) begin
      resp_buf_v_d = 1'b0;
    end else if (need_resp && counted_ok && !wb_allowin && !resp_buf_v_q) begin
      resp_buf_v_d = 1'b1;
      resp_buf_d   = data_sram_rdata;
    end

    inc = 2'd0;
    if (flush) begin
      inc = {1'b0, need_resp & ~resp_got} + {1'b0, ex_mem_valid & ex_req_issued};
    end
    dec     = data_sram_data_ok & ~cnt_zero;
    cnt_sum = {2'b00, discard_cnt_q} + {{DISCARD_W{1'b0}}, inc}
              - {{(DISCARD_W+1){1'b0}}, dec};
    discard_cnt_d = cnt_sum[DISCARD_W-1:0];
    if (cnt_sum > {2'b00, CntMax}) begin
      discard_cnt_d = CntMax;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      resp_buf_v_q  <= 1'b0;
      resp_buf_q    <= 32'd0;
      discard_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      resp_buf_v_q  <= resp_buf_v_d;
      resp_buf_q    <= resp_buf_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // Payload registers load whenever a new instruction is accepted from EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= 32'd0;
      gr_we_q      <= 1'b0;
      dest_q       <= 5'd0;
      alu_result_q <= 32'd0;
      ld_op_q      <= 3'd0;
      req_issued_q <= 1'b0;
      ex_q         <= 1'b0;
      ecode_q      <= 6'd0;
      esubcode_q   <= 9'd0;
    end else if (capture) begin
      pc_q         <= ex_pc;
      gr_we_q      <= ex_gr_we;
      dest_q       <= ex_dest;
      alu_result_q <= ex_alu_result;
      ld_op_q      <= ex_ld_op;
      req_issued_q <= ex_req_issued;
      ex_q         <= ex_ex;
      ecode_q      <= ex_ecode;
      esubcode_q   <= ex_esubcode;
    end
  end

  // Select the byte/halfword lane and sign- or zero-extend the load data.
  always_comb begin
    src_data = resp_buf_v_q ? resp_buf_q : data_sram_rdata;
    case (alu_result_q[1:0])
      2'd0:    byte_v = src_data[7:0];
      2'd1:    byte_v = src_data[15:8];
      2'd2:    byte_v = src_data[23:16];
      default: byte_v = src_data[31:24];
    endcase
    half_v  = alu_result_q[1] ? src_data[31:16] : src_data[15:0];
    is_load = (ld_op_q != 3'b111);
    case (ld_op_q)
      3'b001:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b010:  load_data = {{16{half_v[15]}}, half_v};
      3'b011:  load_data = {24'd0, byte_v};
      3'b100:  load_data = {16'd0, half_v};
      default: load_data = src_data;
    endcase
    mem_result = 32'd0;
    if (valid_q) begin
      mem_result = is_load ? load_data : alu_result_q;
    end
  end

  // WB payload and the ID forwarding/blocking bus.
  always_comb begin
    mem_pc       = pc_q;
    mem_vaddr    = alu_result_q;
    mem_gr_we    = gr_we_q & ~ex_q;
    mem_dest     = dest_q;
    mem_ex       = valid_q & ex_q;
    mem_ecode    = ecode_q;
    mem_esubcode = esubcode_q;
    fwd_we       = valid_q & gr_we_q & ~ex_q;
    fwd_dest     = dest_q;
    block_base   = valid_q & is_load & ~ex_q & ~resp_buf_v_q;
`ifdef MEM_LOAD_BYPASS_EN
    fwd_block    = block_base & ~(need_resp & counted_ok);
`else
    fwd_block    = block_base;
`endif
    fwd_data     = fwd_block ? 32'd0 : mem_result;
  end

endmodule
